rf_8x16: RTL and testbench



---
 rtl/rf_8x16_if.sv | 46 ++++
 rtl/rf_8x16.sv | 134 +++++++++++++
 tb/tb_rf_8x16.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_8x16_if.sv
// ---------------------------------------------------------------------------
// rf_8x16_if
// Bus bundle for the 8x16 register file: two read ports and one write port.
//
// Signals:
//   read1RegSel [2:0]  register index for read port 1
//   read2RegSel [2:0]  register index for read port 2
//   writeRegSel [2:0]  register index for the write port
//   writeData   [15:0] data to write
//   writeEn            write enable, active-high
//   read1Data   [15:0] contents of register read1RegSel
//   read2Data   [15:0] contents of register read2RegSel
//
// Modports:
//   master - the datapath side driving selects and write data
//   slave  - the register file itself
// ---------------------------------------------------------------------------
interface rf_8x16_if;
   logic [2:0]  read1RegSel;
   logic [2:0]  read2RegSel;
   logic [2:0]  writeRegSel;
   logic [15:0] writeData;
   logic        writeEn;
   logic [15:0] read1Data;
   logic [15:0] read2Data;

   modport master (
      output read1RegSel,
      output read2RegSel,
      output writeRegSel,
      output writeData,
      output writeEn,
      input  read1Data,
      input  read2Data
   );

   modport slave (
      input  read1RegSel,
      input  read2RegSel,
      input  writeRegSel,
      input  writeData,
      input  writeEn,
      output read1Data,
      output read2Data
   );
endinterface

// File: rtl/rf_8x16.sv
// ---------------------------------------------------------------------------
// rf_8x16
// 8-entry x 16-bit general-purpose register file with two combinational
// read ports and one synchronous write port. R0 is an ordinary register.
//
// Built hierarchically:
//   rf_bit_dff     - one storage bit: D flip-flop with async reset and a
//                    hold/load feedback mux acting as the enable
//   rf_reg16       - 16 rf_bit_dff cells sharing one enable
//   rf_decoder3to8 - write decoder, out[i] = writeEn & (writeRegSel == i)
//   rf_mux8x16     - 8:1 x 16-bit read multiplexer (one per read port)
//
// Ports (top):
//   clk - system clock, state updates on the rising edge
//   rst - asynchronous active-high reset, clears all 128 storage bits
//   bus - rf_8x16_if.slave: selects, write data/enable, read data
//
// There is no write-to-read forwarding: a read of the register being
// written returns the old value until the writing edge has happened.
// ---------------------------------------------------------------------------

// One storage bit. The enable is a feedback mux in front of the flop so the
// clock is never gated; reset dominates and therefore also blocks writes.
module rf_bit_dff (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic d,
   output logic q
);
   logic next_q;

   // Hold the current value unless this bit's register is being loaded.
   always_comb begin
      next_q = en ? d : q;
   end

   // Storage element with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= 1'b0;
      else
         q <= next_q;
   end
endmodule

// 16-bit register assembled from individual bit cells sharing one enable.
module rf_reg16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] d,
   output logic [15:0] q
);
   for (genvar b = 0; b < 16; b++) begin : g_bit
      rf_bit_dff u_bit (
         .clk (clk),
         .rst (rst),
         .en  (en),
         .d   (d[b]),
         .q   (q[b])
      );
   end
endmodule

// 3-to-8 write decoder; all outputs low when the write enable is low.
module rf_decoder3to8 (
   input  logic       en,
   input  logic [2:0] sel_in,
   output logic [7:0] dec_out
);
   // One-hot select qualified by the write enable.
   always_comb begin
      dec_out = '0;
      for (int i = 0; i < 8; i++) begin
         dec_out[i] = en && (sel_in == 3'(i));
      end
   end
endmodule

// 8:1 x 16-bit read multiplexer.
module rf_mux8x16 (
   input  logic [7:0][15:0] data_in,
   input  logic [2:0]       sel,
   output logic [15:0]      data_out
);
   // Pure combinational selection, zero-cycle latency.
   always_comb begin
      data_out = data_in[sel];
   end
endmodule

// Top level: decoder driving eight registers, two read muxes on the outputs.
module rf_8x16 (
   input  logic      clk,
   input  logic      rst,
   rf_8x16_if.slave  bus
);
   logic [7:0]       write_sel;
   logic [7:0][15:0] reg_q;
   logic [15:0]      rd1_data;
   logic [15:0]      rd2_data;

   rf_decoder3to8 u_dec (
      .en      (bus.writeEn),
      .sel_in  (bus.writeRegSel),
      .dec_out (write_sel)
   );

   for (genvar r = 0; r < 8; r++) begin : g_reg
      rf_reg16 u_reg (
         .clk (clk),
         .rst (rst),
         .en  (write_sel[r]),
         .d   (bus.writeData),
         .q   (reg_q[r])
      );
   end

   rf_mux8x16 u_rd1 (
      .data_in  (reg_q),
      .sel      (bus.read1RegSel),
      .data_out (rd1_data)
   );

   rf_mux8x16 u_rd2 (
      .data_in  (reg_q),
      .sel      (bus.read2RegSel),
      .data_out (rd2_data)
   );

   assign bus.read1Data = rd1_data;
   assign bus.read2Data = rd2_data;
endmodule

// File: tb/tb_rf_8x16.sv
// ---------------------------------------------------------------------------
// tb_rf_8x16
// Self-checking bench for rf_8x16. A table of {inputs, expected pre-edge
// read values} records is applied one per clock; each applied record pushes
// its expectation into a scoreboard queue which is popped and compared
// against both read ports. A behavioural 8x16 array model tracks writes at
// every rising edge and supplies expectations for the reset, async-reset and
// random phases.
// ---------------------------------------------------------------------------
module tb_rf_8x16;
   logic clk;
   logic rst;

   rf_8x16_if bus ();

   rf_8x16 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  r1;
      logic [2:0]  r2;
      logic [2:0]  ws;
      logic [15:0] wd;
      logic        we;
      logic [15:0] exp1;
      logic [15:0] exp2;
   } vec_t;

   typedef struct {
      logic [15:0] exp1;
      logic [15:0] exp2;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   vec_t        vecs[$];
   logic [15:0] model [8];
   int          total = 0;
   int          bad   = 0;

   function automatic vec_t mk(input logic [2:0] r1, input logic [2:0] r2,
                               input logic [2:0] ws, input logic [15:0] wd,
                               input logic we, input logic [15:0] e1,
                               input logic [15:0] e2);
      vec_t v;
      v.r1 = r1; v.r2 = r2; v.ws = ws; v.wd = wd; v.we = we;
      v.exp1 = e1; v.exp2 = e2;
      return v;
   endfunction

   // Pop the oldest expectation and compare it with both read ports.
   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
         return;
      end
      e = sb.pop_front();
      total++;
      if (bus.read1Data !== e.exp1) begin
         bad++;
         $display("[TB] FAIL %s read1: got %h required %h", e.tag, bus.read1Data, e.exp1);
      end
      total++;
      if (bus.read2Data !== e.exp2) begin
         bad++;
         $display("[TB] FAIL %s read2: got %h required %h", e.tag, bus.read2Data, e.exp2);
      end
   endtask

   // Drive one record at the falling edge, check the pre-edge reads, then
   // let the rising edge happen and mirror any write into the model.
   task automatic applyStimulus(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      bus.read1RegSel = v.r1;
      bus.read2RegSel = v.r2;
      bus.writeRegSel = v.ws;
      bus.writeData   = v.wd;
      bus.writeEn     = v.we;
      e.exp1 = v.exp1;
      e.exp2 = v.exp2;
      e.tag  = tag;
      sb.push_back(e);
      #1;
      checkOutput();
      @(posedge clk);
      if (!rst && v.we)
         model[v.ws] = v.wd;
   endtask

   task automatic pushZeros(input string tag);
      exp_t e;
      e.exp1 = 16'h0000;
      e.exp2 = 16'h0000;
      e.tag  = tag;
      sb.push_back(e);
   endtask

   // Watchdog: the run is clock-bounded, this only guards against a stall.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t v;
      logic [2:0]  rs1, rs2, wsel;
      logic [15:0] wdat;
      logic        wen;

      // Reset asserted from time zero with a write pending on R3.
      rst             = 1'b1;
      bus.read1RegSel = 3'd0;
      bus.read2RegSel = 3'd7;
      bus.writeRegSel = 3'd3;
      bus.writeData   = 16'hFFFF;
      bus.writeEn     = 1'b1;
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;

      // ---- Table: basic write, write disable, all registers, same-cycle ----
      vecs.push_back(mk(3'd5, 3'd5, 3'd5, 16'h1234, 1'b1, 16'h0000, 16'h0000));
      vecs.push_back(mk(3'd5, 3'd5, 3'd2, 16'hBEEF, 1'b0, 16'h1234, 16'h1234));
      vecs.push_back(mk(3'd2, 3'd5, 3'd2, 16'hBEEF, 1'b0, 16'h0000, 16'h1234));
      vecs.push_back(mk(3'd2, 3'd2, 3'd2, 16'hBEEF, 1'b0, 16'h0000, 16'h0000));
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk(3'(i), 3'(i), 3'(i), 16'(16'h1111 * i), 1'b1,
                           (i == 5) ? 16'h1234 : 16'h0000,
                           (i == 5) ? 16'h1234 : 16'h0000));
      end
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk(3'(i), 3'(7 - i), 3'd0, 16'hDEAD, 1'b0,
                           16'(16'h1111 * i), 16'(16'h1111 * (7 - i))));
      end
      vecs.push_back(mk(3'd4, 3'd0, 3'd4, 16'h00AA, 1'b1, 16'h4444, 16'h0000));
      vecs.push_back(mk(3'd4, 3'd4, 3'd4, 16'h5555, 1'b1, 16'h00AA, 16'h00AA));
      vecs.push_back(mk(3'd4, 3'd3, 3'd4, 16'h5555, 1'b0, 16'h5555, 16'h3333));

      // ---- Reset with writeEn=1 to R3: every register reads zero ----
      for (int i = 0; i < 8; i++) begin
         applyStimulus(mk(3'(i), 3'(7 - i), 3'd3, 16'hFFFF, 1'b1,
                          16'h0000, 16'h0000), "reset_hold");
      end
      @(negedge clk);
      rst = 1'b0;
      bus.writeEn = 1'b0;
      bus.read1RegSel = 3'd3;
      bus.read2RegSel = 3'd3;
      pushZeros("reset_release_r3");
      #1;
      checkOutput();

      // ---- Table-driven section ----
      for (int k = 0; k < vecs.size(); k++) begin
         applyStimulus(vecs[k], $sformatf("vec%0d", k));
      end

      // ---- Asynchronous reset between clock edges ----
      @(negedge clk);
      bus.writeEn     = 1'b0;
      bus.read1RegSel = 3'd7;
      bus.read2RegSel = 3'd1;
      #2;
      rst = 1'b1;
      pushZeros("async_reset");
      #1;
      checkOutput();
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      @(negedge clk);
      rst = 1'b0;
      bus.read1RegSel = 3'd4;
      bus.read2RegSel = 3'd6;
      pushZeros("after_async_reset");
      #1;
      checkOutput();

      // ---- Random regression against the array model ----
      for (int n = 0; n < 80; n++) begin
         rs1  = 3'($urandom_range(0, 7));
         rs2  = 3'($urandom_range(0, 7));
         wsel = 3'($urandom_range(0, 7));
         wdat = 16'($urandom);
         wen  = 1'($urandom_range(0, 1));
         v = mk(rs1, rs2, wsel, wdat, wen, model[rs1], model[rs2]);
         applyStimulus(v, $sformatf("rand%0d", n));
      end

      // Final sweep of every register after the random phase.
      for (int i = 0; i < 8; i++) begin
         v = mk(3'(i), 3'(7 - i), 3'd0, 16'h0000, 1'b0, model[i], model[7 - i]);
         applyStimulus(v, $sformatf("final%0d", i));
      end

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
